// File: rtl/inst_cache_pkg.sv
// Shared sizing constants and refill FSM encoding for the instruction cache.
package inst_cache_pkg;

    localparam int          DataSize     = 32;
    localparam logic [31:0] DataBusReset = 32'h0000_0000;
    localparam int          ICacheLines  = 16;
    localparam int          ICacheWords  = 4;

    typedef enum logic [1:0] {
        IC_IDLE   = 2'd0,
        IC_REFILL = 2'd1,
        IC_DONE   = 2'd2
    } icState_t;

endpackage

// File: rtl/inst_cache_refill.sv
// Miss handling for the instruction cache: refill FSM, word counter,
// memory req/ack handshake and deferred flush bookkeeping.
module inst_cache_refill
    import inst_cache_pkg::*;
#(
    parameter int ADDR_W = DataSize,
    parameter int LINES  = ICacheLines,
    parameter int WORDS  = ICacheWords,
    localparam int OFF_W = $clog2(WORDS),
    localparam int IDX_W = $clog2(LINES),
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2
) (
    input  logic                   clk,
    input  logic                   resetIn,
    input  logic [TAG_W+IDX_W-1:0] lineAddr,
    input  logic                   lookupHit,
    input  logic                   flushIn,
    input  logic                   memAck,
    output logic                   memReq,
    output logic [ADDR_W-1:0]      memAddr,
    output logic                   idle,
    output logic                   fillWe,
    output logic [OFF_W-1:0]       fillWord,
    output logic [IDX_W-1:0]       fillIdx,
    output logic [TAG_W-1:0]       fillTag,
    output logic                   fillDone,
    output logic                   invalidate
);

    icState_t         state;
    icState_t         stateNext;
    logic [OFF_W-1:0] wordCnt;
    logic [IDX_W-1:0] victimIdx;
    logic [TAG_W-1:0] victimTag;
    logic             flushPending;
    logic             startMiss;
    logic             ackTake;
    logic             lastAck;

    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            state <= IC_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A flush in IDLE takes priority over a miss; the miss is re-evaluated next cycle.
    always_comb begin
        stateNext = state;
        startMiss = 1'b0;
        ackTake   = 1'b0;
        lastAck   = 1'b0;
        case (state)
            IC_IDLE: begin
                if (!flushIn && !lookupHit) begin
                    startMiss = 1'b1;
                    stateNext = IC_REFILL;
                end
            end
            IC_REFILL: begin
                if (memReq && memAck) begin
                    ackTake = 1'b1;
                    if (&wordCnt) begin
                        lastAck   = 1'b1;
                        stateNext = IC_DONE;
                    end
                end
            end
            IC_DONE: stateNext = IC_IDLE;
            default: stateNext = IC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            memReq    <= 1'b0;
            memAddr   <= '0;
            wordCnt   <= '0;
            victimIdx <= '0;
            victimTag <= '0;
        end else if (startMiss) begin
            memReq    <= 1'b1;
            memAddr   <= {lineAddr, {(OFF_W + 2){1'b0}}};
            wordCnt   <= '0;
            victimIdx <= lineAddr[IDX_W-1:0];
            victimTag <= lineAddr[TAG_W+IDX_W-1:IDX_W];
        end else if (ackTake) begin
            memAddr <= memAddr + ADDR_W'(4);
            if (lastAck) begin
                memReq <= 1'b0;
            end else begin
                wordCnt <= wordCnt + 1'b1;
            end
        end
    end

    // Flushes seen while busy are replayed as the FSM re-enters IDLE.
    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            flushPending <= 1'b0;
        end else if (state == IC_DONE) begin
            flushPending <= 1'b0;
        end else if (flushIn && state != IC_IDLE) begin
            flushPending <= 1'b1;
        end
    end

    assign idle       = (state == IC_IDLE);
    assign fillWe     = ackTake;
    assign fillWord   = wordCnt;
    assign fillIdx    = victimIdx;
    assign fillTag    = victimTag;
    assign fillDone   = lastAck;
    assign invalidate = (idle && flushIn) ||
                        (state == IC_DONE && (flushPending || flushIn));

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache between PC and IF_ID; ready
// doubles as the PC hold signal while a line is refilled.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int ADDR_W = DataSize,
    parameter int LINES  = ICacheLines,
    parameter int WORDS  = ICacheWords
) (
    input  logic              clk,
    input  logic              resetIn,
    input  logic [ADDR_W-1:0] addrIn,
    input  logic              flushIn,
    output logic [31:0]       instOut,
    output logic              ready,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [31:0]       memData
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    logic [LINES-1:0] validArr;
    logic [TAG_W-1:0] tagArr  [LINES];
    logic [31:0]      dataArr [LINES*WORDS];

    logic [OFF_W-1:0] offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             unusedByteBits;
    logic             lookupHit;

    logic             idle;
    logic             fillWe;
    logic [OFF_W-1:0] fillWord;
    logic [IDX_W-1:0] fillIdx;
    logic [TAG_W-1:0] fillTag;
    logic             fillDone;
    logic             invalidate;

    assign offset         = addrIn[OFF_W+1:2];
    assign index          = addrIn[OFF_W+IDX_W+1:OFF_W+2];
    assign tag            = addrIn[ADDR_W-1:OFF_W+IDX_W+2];
    assign unusedByteBits = ^addrIn[1:0];

    // Zero-cycle lookup; a flush in the same cycle suppresses the hit.
    assign lookupHit = validArr[index] && (tagArr[index] == tag);
    assign ready     = idle && lookupHit && !flushIn;
    assign instOut   = ready ? dataArr[{index, offset}] : DataBusReset;

    inst_cache_refill #(
        .ADDR_W (ADDR_W),
        .LINES  (LINES),
        .WORDS  (WORDS)
    ) refill (
        .clk        (clk),
        .resetIn    (resetIn),
        .lineAddr   (addrIn[ADDR_W-1:OFF_W+2]),
        .lookupHit  (lookupHit),
        .flushIn    (flushIn),
        .memAck     (memAck),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .idle       (idle),
        .fillWe     (fillWe),
        .fillWord   (fillWord),
        .fillIdx    (fillIdx),
        .fillTag    (fillTag),
        .fillDone   (fillDone),
        .invalidate (invalidate)
    );

    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            validArr <= '0;
        end else if (invalidate) begin
            validArr <= '0;
        end else if (fillDone) begin
            validArr[fillIdx] <= 1'b1;
        end
    end

    // Tags and data carry no reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (fillDone) begin
            tagArr[fillIdx] <= fillTag;
        end
        if (fillWe) begin
            dataArr[{fillIdx, fillWord}] <= memData;
        end
    end

endmodule
